// File: rtl/factorial_pkg.sv
// Shared types and constants for the factorial BCD display path.
// Holds the converter FSM state encoding, default widths and the
// double-dabble nibble-correction constants.
package factorial_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int BIN_W_DEF  = 32;
    localparam int DIGITS_DEF = 10;

    // A nibble at or above ADJ_THRESH would exceed 9 after the next shift,
    // so ADJ_INC is added first to carry it into the next decimal digit.
    localparam logic [3:0] ADJ_THRESH = 4'd5;
    localparam logic [3:0] ADJ_INC    = 4'd3;

    // True when DIGITS decimal digits can hold every BIN_W-bit unsigned value.
    function automatic bit digits_cover(input int bin_w, input int digits);
        logic [255:0] pow10;
        logic [255:0] max_bin;
        pow10   = 256'd1;
        max_bin = (256'd1 << bin_w) - 256'd1;
        for (int i = 0; i < digits; i++) begin
            pow10 = pow10 * 256'd10;
        end
        return pow10 > max_bin;
    endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// One double-dabble correction stage: a BCD nibble of 5 or more gets 3
// added so that the following left shift carries into the next digit.
import factorial_pkg::*;

module bcd_digit_adjust (
    input  logic [3:0] nib_i,
    output logic [3:0] nib_o
);

    // Combinational add-3 correction.
    always_comb begin
        nib_o = nib_i;
        if (nib_i >= ADJ_THRESH) begin
            nib_o = nib_i + ADJ_INC;
        end
    end

endmodule

// File: rtl/factorial_bcd_convert.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per
// clock. start/busy/done handshake: start is sampled only while idle and
// captures bin on that edge; busy is high for the whole conversion; done
// pulses for one cycle when bcd/digit_en carry the new result, which is
// then held until the next done.
// Build option: FACTORIAL_BCD_BLANK_EN enables leading-zero blanking on
// digit_en; without it digit_en is all ones.
import factorial_pkg::*;

module factorial_bcd_convert #(
    parameter int BIN_W  = BIN_W_DEF,
    parameter int DIGITS = DIGITS_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [DIGITS-1:0]     digit_en
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int SCR_W = BCD_W + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);

`ifdef FACTORIAL_BCD_BLANK_EN
    localparam logic [DIGITS-1:0] EN_RST = DIGITS'(1);
`else
    localparam logic [DIGITS-1:0] EN_RST = '1;
`endif

    if (!digits_cover(BIN_W, DIGITS)) begin : g_cfg_bad
        $error("factorial_bcd_convert: DIGITS too small to hold 2^BIN_W-1");
    end

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [SCR_W-1:0]    scratch_q, scratch_d;
    logic [BCD_W-1:0]    bcd_q, bcd_d;
    logic [DIGITS-1:0]   digit_en_q, digit_en_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [BCD_W-1:0]    adj_bcd;
    logic [SCR_W-1:0]    shifted;
    logic [DIGITS-1:0]   en_next;

    // Per-digit add-3 correction on the BCD half of the scratch register.
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .nib_i (scratch_q[BIN_W + 4*g +: 4]),
            .nib_o (adj_bcd[4*g +: 4])
        );
    end

    // Corrected digits and remaining binary bits, shifted left by one.
    assign shifted = {adj_bcd[BCD_W-2:0], scratch_q[BIN_W-1:0], 1'b0};

`ifdef FACTORIAL_BCD_BLANK_EN
    // Enable a digit once it or any more significant digit is nonzero;
    // digit 0 always shows so a zero result displays a single "0".
    always_comb begin
        logic seen;
        seen    = 1'b0;
        en_next = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            seen       = seen | (scratch_q[BIN_W + 4*i +: 4] != 4'd0);
            en_next[i] = seen;
        end
        en_next[0] = 1'b1;
    end
`else
    assign en_next = '1;
`endif

    // Next-state and datapath control for the IDLE/SHIFT/DONE sequence.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        scratch_d  = scratch_q;
        bcd_d      = bcd_q;
        digit_en_d = digit_en_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    scratch_d = {{BCD_W{1'b0}}, bin};
                    cnt_d     = CNT_W'(BIN_W);
                    busy_d    = 1'b1;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                scratch_d = shifted;
                cnt_d     = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bcd_d      = scratch_q[SCR_W-1:BIN_W];
                digit_en_d = en_next;
                done_d     = 1'b1;
                busy_d     = 1'b0;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any conversion in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            scratch_q  <= '0;
            bcd_q      <= '0;
            digit_en_q <= EN_RST;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            scratch_q  <= scratch_d;
            bcd_q      <= bcd_d;
            digit_en_q <= digit_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign bcd      = bcd_q;
    assign digit_en = digit_en_q;

endmodule

// File: tb/tb_factorial_bcd_convert.sv
// Bench for factorial_bcd_convert: expected BCD, digit enables and done
// cycle are queued when a conversion is launched and compared when done
// pulses. Build option: FACTORIAL_BCD_BLANK_EN selects the blanking model.
module tb_factorial_bcd_convert;

  localparam int BIN_W  = 32;
  localparam int DIGITS = 10;
  localparam int LAT    = BIN_W + 1;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic [BIN_W-1:0]    bin;
  logic                busy;
  logic                done;
  logic [4*DIGITS-1:0] bcd;
  logic [DIGITS-1:0]   digit_en;

  factorial_bcd_convert #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bin      (bin),
    .busy     (busy),
    .done     (done),
    .bcd      (bcd),
    .digit_en (digit_en)
  );

  // clock / cycle counter
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard
  logic [4*DIGITS-1:0] exp_q[$];
  logic [DIGITS-1:0]   exp_en_q[$];
  int unsigned         exp_cyc_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [4*DIGITS-1:0] to_bcd(input logic [BIN_W-1:0] v);
    logic [4*DIGITS-1:0] r;
    longint unsigned x;
    x = longint'(v);
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [DIGITS-1:0] to_en(input logic [4*DIGITS-1:0] b);
`ifdef FACTORIAL_BCD_BLANK_EN
    int h;
    logic [DIGITS:0] t;
    h = 0;
    for (int i = 0; i < DIGITS; i++) if (b[4*i +: 4] != 4'd0) h = i;
    t = ({{DIGITS{1'b0}}, 1'b1} << (h + 1)) - 1;
    return t[DIGITS-1:0];
`else
    if (b === 'x) return '0;
    return '1;
`endif
  endfunction

  function automatic logic [DIGITS-1:0] en_reset();
`ifdef FACTORIAL_BCD_BLANK_EN
    return DIGITS'(1);
`else
    return '1;
`endif
  endfunction

  // monitor: every done must match the oldest queued expectation
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_done", 64'd1, 64'd0);
      end else begin
        check("bcd", 64'(bcd), 64'(exp_q.pop_front()));
        check("digit_en", 64'(digit_en), 64'(exp_en_q.pop_front()));
        check("done_cycle", 64'(cyc), 64'(exp_cyc_q.pop_front()));
        check("busy_at_done", 64'(busy), 64'd0);
      end
    end
  end

  // driver: called just after a negedge; start held across one rising edge
  task automatic start_conv(input logic [BIN_W-1:0] v, input bit push);
    logic [4*DIGITS-1:0] b;
    start = 1'b1;
    bin   = v;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    if (push) begin
      b = to_bcd(v);
      exp_q.push_back(b);
      exp_en_q.push_back(to_en(b));
      exp_cyc_q.push_back(cyc + LAT);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (exp_q.size() != 0) begin
      check("timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
      exp_en_q.delete();
      exp_cyc_q.delete();
    end
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    if (!seen) check("wait_done_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    bin   = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_bcd", 64'(bcd), 64'd0);
    check("rst_digit_en", 64'(digit_en), 64'(en_reset()));
    rst = 1'b0;
    @(negedge clk);

    // basic values and the all-ones boundary
    start_conv(32'd0, 1'b1);
    check("busy_running", 64'(busy), 64'd1);
    drain();
    start_conv(32'd3628800, 1'b1);
    drain();
    start_conv(32'hFFFF_FFFF, 1'b1);
    drain();
    for (int i = 0; i < 4; i++) begin
      start_conv($urandom(), 1'b1);
      drain();
    end

    // a start during a conversion is ignored
    start_conv(32'd479001600, 1'b1);
    repeat (8) @(negedge clk);
    start = 1'b1;
    bin   = 32'd5;
    @(negedge clk);
    start = 1'b0;
    bin   = '0;
    drain();
    repeat (40) @(negedge clk);

    // reset mid-conversion aborts; no done and bcd cleared
    start_conv(32'd12345, 1'b0);
    repeat (13) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_bcd", 64'(bcd), 64'd0);
    check("abort_digit_en", 64'(digit_en), 64'(en_reset()));
    repeat (45) @(negedge clk);
    check("abort_idle", 64'(busy), 64'd0);
    start_conv(32'd120, 1'b1);
    drain();

    // back-to-back: start during the done cycle, first result held
    start_conv(32'd24, 1'b1);
    wait_done();
    start_conv(32'd720, 1'b1);
    repeat (15) @(negedge clk);
    check("held_bcd", 64'(bcd), 64'(to_bcd(32'd24)));
    check("held_busy", 64'(busy), 64'd1);
    drain();

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
